mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_dwell_cnt.sv | 32 +++
 rtl/mux_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer.
//   state_e   - sequencer states (IDLE, SETTLE, HOLD)
//   NUM_CH    - number of mux channels scanned (fixed at 4)
//   SEL_W     - width of the mux select
//   SEL_LAST  - select value of the last channel in a scan
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam logic [SEL_W-1:0] SEL_LAST = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt: loadable down-counter timing the dwell on each channel.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears count)
//   load        - load load_val (wins over dec)
//   dec         - decrement by one; saturates at zero
//   load_val    - value to load
//   cnt         - current count
//   zero        - cnt == 0
module mux_scan_dwell_cnt #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               dec,
   input  logic [DWELL_W-1:0] load_val,
   output logic [DWELL_W-1:0] cnt,
   output logic               zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the select of a downstream 4:1 mux through all
// channels, holds each for dwell_cfg+1 cycles, samples the mux output at the
// end of each dwell and offers the four captured bits on a valid/ready port.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - begins a scan when idle (dwell_cfg latched here)
//   abort           - cancels a scan in progress; ignored when idle
//   dwell_cfg       - dwell setting, cycles per channel = dwell_cfg+1
//   y_in            - mux output
//   sel             - mux select
//   busy            - scan in progress or result pending
//   samples         - bit i = y_in captured while sel == i
//   samples_valid   - result word valid
//   samples_ready   - consumer ready
// Build option: MUX_SCAN_AUTO_RESCAN_EN - after the result handshake, start
// the next scan immediately with the latched dwell instead of going idle.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [DWELL_W-1:0] dwell_cfg,
   input  logic               y_in,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic [NUM_CH-1:0]  samples,
   output logic               samples_valid,
   input  logic               samples_ready
);

   state_e             state;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_val;
   logic               cnt_zero;
   logic               cnt_load;
   logic               cnt_dec;
   logic               hs;
   logic               rescan;

   assign hs = samples_valid && samples_ready;

`ifdef MUX_SCAN_AUTO_RESCAN_EN
   assign rescan = 1'b1;
`else
   assign rescan = 1'b0;
`endif

   // Counter is loaded from the live input only on scan start; every later
   // reload uses the latched copy so dwell_cfg changes mid-scan are ignored.
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = dwell_q;
      if (!abort) begin
         case (state)
            IDLE: begin
               cnt_load = start;
               cnt_val  = dwell_cfg;
            end
            SETTLE: begin
               cnt_load = cnt_zero && (sel != SEL_LAST);
               cnt_dec  = !cnt_zero;
            end
            HOLD:    cnt_load = hs && rescan;
            default: ;
         endcase
      end
   end

   mux_scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         dwell_q       <= '0;
         sel           <= '0;
         busy          <= 1'b0;
         samples       <= '0;
         samples_valid <= 1'b0;
      end else if (abort) begin
         // Abort also blocks a simultaneous start in IDLE; samples are kept.
         state         <= IDLE;
         sel           <= '0;
         busy          <= 1'b0;
         samples_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sel <= '0;
               if (start) begin
                  dwell_q <= dwell_cfg;
                  busy    <= 1'b1;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_zero) begin
                  samples[sel] <= y_in;
                  if (sel == SEL_LAST) begin
                     samples_valid <= 1'b1;
                     state         <= HOLD;
                  end else begin
                     sel <= sel + 2'd1;
                  end
               end
            end
            HOLD: begin
               if (hs) begin
                  samples_valid <= 1'b0;
                  sel           <= '0;
                  if (rescan) begin
                     state <= SETTLE;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic unused_cnt;
   assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed and randomized checks of the mux scan
// sequencer against a timing/capture model derived from the dwell arithmetic.
// Build option: MUX_SCAN_AUTO_RESCAN_EN selects the rescan expectations.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] dwell_cfg = '0;
   logic       y_in;
   logic [1:0] sel;
   logic       busy;
   logic [3:0] samples;
   logic       samples_valid;
   logic       samples_ready = 1'b0;

   logic [3:0] ch_in = 4'b0101;   // mux data inputs A..D as bits 0..3
   logic [3:0] exp_s;             // model of the samples register

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Downstream 4:1 mux.
   assign y_in = ch_in[sel];

   mux_scan_sequencer #(.DWELL_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .dwell_cfg     (dwell_cfg),
      .y_in          (y_in),
      .sel           (sel),
      .busy          (busy),
      .samples       (samples),
      .samples_valid (samples_valid),
      .samples_ready (samples_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full scan with dwell d and channel data ch. Expected sel after edge k is
   // k/(d+1); result valid after edge 4*(d+1). Start and dwell_cfg are
   // disturbed mid-scan and must have no effect.
   task automatic scan_body(input int d, input logic [3:0] ch);
      int n;
      n = 4 * (d + 1);
      for (int k = 1; k < n; k++) begin
         start     = (k == 3);
         dwell_cfg = 4'($urandom);
         step();
         start = 1'b0;
         check("sel_step", 32'(sel), 32'(k / (d + 1)));
         check("valid_low", 32'(samples_valid), 32'd0);
      end
      step();
      exp_s = ch;
      check("valid_rise", 32'(samples_valid), 32'd1);
      check("samples", 32'(samples), 32'(exp_s));
      check("busy_hold", 32'(busy), 32'd1);
   endtask

   task automatic run_scan(input int d, input logic [3:0] ch, input int stall);
      ch_in     = ch;
      dwell_cfg = 4'(d);
      start     = 1'b1;
      step();
      start = 1'b0;
      check("busy_start", 32'(busy), 32'd1);
      check("sel_start", 32'(sel), 32'd0);
      scan_body(d, ch);
      for (int r = 0; r < stall; r++) begin
         ch_in = 4'($urandom);
         step();
         check("stall_valid", 32'(samples_valid), 32'd1);
         check("stall_samples", 32'(samples), 32'(exp_s));
      end
      ch_in         = ch;
      samples_ready = 1'b1;
      start         = 1'b1;   // start in the handshake cycle is ignored
      step();
      samples_ready = 1'b0;
      start         = 1'b0;
      check("hs_valid", 32'(samples_valid), 32'd0);
      check("hs_sel", 32'(sel), 32'd0);
`ifdef MUX_SCAN_AUTO_RESCAN_EN
      check("hs_busy", 32'(busy), 32'd1);
      scan_body(d, ch);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("rescan_abort_busy", 32'(busy), 32'd0);
      check("rescan_abort_valid", 32'(samples_valid), 32'd0);
`else
      check("hs_busy", 32'(busy), 32'd0);
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sel", 32'(sel), 32'd0);
`endif
   endtask

   initial begin
      exp_s = '0;
      #12;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(samples_valid), 32'd0);
      check("rst_samples", 32'(samples), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed scans: dwell 2 then dwell 0, A=1 B=0 C=1 D=0.
      run_scan(2, 4'b0101, 5);
      run_scan(0, 4'b0101, 0);

      // Abort at edge 4 of a dwell-2 scan: only channel 0 was captured.
      ch_in     = 4'b1010;
      dwell_cfg = 4'd2;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k < 4; k++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_s[0] = ch_in[0];
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_sel", 32'(sel), 32'd0);
      check("abort_valid", 32'(samples_valid), 32'd0);
      check("abort_samples", 32'(samples), 32'(exp_s));
      step();
      check("abort_idle_busy", 32'(busy), 32'd0);

      // Randomized scans.
      for (int i = 0; i < 6; i++)
         run_scan(int'($urandom_range(0, 3)), 4'($urandom), int'($urandom_range(0, 3)));

      // Asynchronous reset in the middle of channel 2 (dwell 2).
      ch_in     = 4'b1111;
      dwell_cfg = 4'd2;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) step();
      check("pre_rst_sel", 32'(sel), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      check("arst_sel", 32'(sel), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(samples_valid), 32'd0);
      check("arst_samples", 32'(samples), 32'd0);
      #2 rst_n = 1'b1;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
